cpu_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/cpu_ctrl_decode.sv | 99 +++++++++
 rtl/cpu_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, state
// encoding and the control word passed from the decoder to the top level.
package cpu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    // SHIFT has no memory operand; the address bus parks on this value.
    localparam logic [4:0] SHIFT_OPERAND = 5'h1f;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC_A = 2'b10,
        ST_EXEC_B = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        NX_HOLD   = 2'b00,
        NX_EXEC_A = 2'b01,
        NX_EXEC_B = 2'b10,
        NX_END    = 2'b11
    } next_cls_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_JMP  = 2'b10,
        PC_JZ   = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        AS_ZERO  = 2'b00,
        AS_PC    = 2'b01,
        AS_OPND  = 2'b10,
        AS_SHIFT = 2'b11
    } addr_sel_t;

    typedef struct packed {
        logic      mem_rd;
        logic      mem_wr;
        logic      use_alu;
        logic      ld_acc;
        logic      dbus_sel;
        logic      ld_ir;
        next_cls_t nxt;
        pc_sel_t   pc_sel;
        addr_sel_t addr_sel;
    } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decoder: (state, opcode, mem_ready) -> strobes, address
// source, pc update kind and next-state class.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    ctrl_t ctrl_s;

    // Strobe and sequencing decode; unlisted combinations end the instruction quietly.
    always_comb begin
        ctrl_s          = '0;
        ctrl_s.nxt      = NX_HOLD;
        ctrl_s.pc_sel   = PC_HOLD;
        ctrl_s.addr_sel = AS_ZERO;
        case (state)
            ST_IDLE: begin
                ctrl_s.nxt = NX_END;
            end
            ST_FETCH: begin
                ctrl_s.addr_sel = AS_PC;
                ctrl_s.mem_rd   = 1'b1;
                if (mem_ready) begin
                    ctrl_s.ld_ir  = 1'b1;
                    ctrl_s.pc_sel = PC_INC;
                    ctrl_s.nxt    = NX_EXEC_A;
                end else begin
                    ctrl_s.nxt = NX_HOLD;
                end
            end
            ST_EXEC_A: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_NAND: begin
                        ctrl_s.addr_sel = AS_OPND;
                        ctrl_s.mem_rd   = 1'b1;
                        ctrl_s.use_alu  = mem_ready;
                        ctrl_s.nxt      = mem_ready ? NX_EXEC_B : NX_HOLD;
                    end
                    OP_LD: begin
                        ctrl_s.addr_sel = AS_OPND;
                        ctrl_s.mem_rd   = 1'b1;
                        ctrl_s.ld_acc   = mem_ready;
                        ctrl_s.nxt      = mem_ready ? NX_END : NX_HOLD;
                    end
                    OP_SHIFT: begin
                        ctrl_s.addr_sel = AS_SHIFT;
                        ctrl_s.use_alu  = 1'b1;
                        ctrl_s.nxt      = NX_EXEC_B;
                    end
                    OP_ST: begin
                        ctrl_s.addr_sel = AS_OPND;
                        ctrl_s.use_alu  = 1'b1;
                        ctrl_s.nxt      = NX_EXEC_B;
                    end
                    OP_JMP: begin
                        ctrl_s.pc_sel = PC_JMP;
                        ctrl_s.nxt    = NX_END;
                    end
                    OP_JZ: begin
                        ctrl_s.pc_sel = PC_JZ;
                        ctrl_s.nxt    = NX_END;
                    end
                    default: begin
                        ctrl_s.nxt = NX_END;
                    end
                endcase
            end
            ST_EXEC_B: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_NAND, OP_SHIFT: begin
                        ctrl_s.addr_sel = AS_OPND;
                        ctrl_s.dbus_sel = 1'b1;
                        ctrl_s.ld_acc   = 1'b1;
                        ctrl_s.nxt      = NX_END;
                    end
                    OP_ST: begin
                        ctrl_s.addr_sel = AS_OPND;
                        ctrl_s.dbus_sel = 1'b1;
                        ctrl_s.mem_wr   = 1'b1;
                        ctrl_s.nxt      = mem_ready ? NX_END : NX_HOLD;
                    end
                    default: begin
                        ctrl_s.nxt = NX_END;
                    end
                endcase
            end
            default: begin
                ctrl_s.nxt = NX_END;
            end
        endcase
    end

    assign ctrl = ctrl_s;

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: holds state, pc and
// IR; strobes are combinational so an asynchronous reset drops them at once.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [4:0] RESET_PC = 5'h00
) (
    input  logic       tclk,
    input  logic       reset,
    input  logic       run,
    input  logic       mem_ready,
    input  logic       z,
    input  logic [7:0] d_bus,
    output logic [4:0] addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] instruction,
    output logic       ldAcc,
    output logic       useAlu,
    output logic       dbusSelect,
    output logic [4:0] pc,
    output logic       busy
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] pc_r;
    logic [4:0] pc_nxt_s;
    logic [7:0] ir_r;
    logic [7:0] ir_nxt_s;
    logic [4:0] addr_s;
    ctrl_t      ctrl_s;

    cpu_ctrl_decode u_decode (
        .state     (state_r),
        .opcode    (ir_r[7:5]),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Next state; an instruction end (and IDLE) re-enters FETCH only while run is high.
    always_comb begin
        state_nxt_s = state_r;
        case (ctrl_s.nxt)
            NX_HOLD:   state_nxt_s = state_r;
            NX_EXEC_A: state_nxt_s = ST_EXEC_A;
            NX_EXEC_B: state_nxt_s = ST_EXEC_B;
            NX_END: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Next pc and IR; a taken jump only ever happens after this instruction's fetch.
    always_comb begin
        pc_nxt_s = pc_r;
        ir_nxt_s = ir_r;
        case (ctrl_s.pc_sel)
            PC_HOLD: pc_nxt_s = pc_r;
            PC_INC:  pc_nxt_s = pc_r + 5'd1;
            PC_JMP:  pc_nxt_s = ir_r[4:0];
            PC_JZ: begin
                if (z) begin
                    pc_nxt_s = ir_r[4:0];
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: pc_nxt_s = pc_r;
        endcase
        if (ctrl_s.ld_ir) begin
            ir_nxt_s = d_bus;
        end else begin
            ir_nxt_s = ir_r;
        end
    end

    // Address source mux.
    always_comb begin
        addr_s = 5'h00;
        case (ctrl_s.addr_sel)
            AS_ZERO:  addr_s = 5'h00;
            AS_PC:    addr_s = pc_r;
            AS_OPND:  addr_s = ir_r[4:0];
            AS_SHIFT: addr_s = SHIFT_OPERAND;
            default:  addr_s = 5'h00;
        endcase
    end

    // State, pc and IR registers.
    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
        end
    end

    assign addr        = addr_s;
    assign mem_rd      = ctrl_s.mem_rd;
    assign mem_wr      = ctrl_s.mem_wr;
    assign useAlu      = ctrl_s.use_alu;
    assign ldAcc       = ctrl_s.ld_acc;
    assign dbusSelect  = ctrl_s.dbus_sel;
    assign instruction = ir_r;
    assign pc          = pc_r;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: a directed per-cycle table, a reset
// during a stalled store, then random programs against an instruction-level model.
module tb_cpu_ctrl;

    logic       tclk      = 1'b0;
    logic       reset     = 1'b1;
    logic       run       = 1'b0;
    logic       mem_ready = 1'b0;
    logic       z         = 1'b0;
    logic [7:0] d_bus;
    logic [4:0] addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] instruction;
    logic       ldAcc;
    logic       useAlu;
    logic       dbusSelect;
    logic [4:0] pc;
    logic       busy;

    logic [7:0] mem [32];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] mpc;
    logic [7:0] mir;

    always #5 tclk = ~tclk;

    assign d_bus = mem_rd ? mem[addr] : 8'h00;

    cpu_ctrl #(.RESET_PC(5'h00)) dut (
        .tclk        (tclk),
        .reset       (reset),
        .run         (run),
        .mem_ready   (mem_ready),
        .z           (z),
        .d_bus       (d_bus),
        .addr        (addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .instruction (instruction),
        .ldAcc       (ldAcc),
        .useAlu      (useAlu),
        .dbusSelect  (dbusSelect),
        .pc          (pc),
        .busy        (busy)
    );

    typedef struct {
        logic       run_i;
        logic       mr_i;
        logic       z_i;
        logic       ca;
        logic [4:0] a;
        logic       rd, wr, ua, la, ds, bsy;
        logic [4:0] p;
        logic [7:0] i;
    } vec_t;

    vec_t tbl [25];

    task automatic expect_obs(input string nm, input logic ca, input logic [4:0] a,
                              input logic rd, input logic wr, input logic ua,
                              input logic la, input logic ds, input logic bsy,
                              input logic [4:0] p, input logic [7:0] i);
        logic [23:0] got_v, exp_v, msk_v;
        got_v = {addr, mem_rd, mem_wr, useAlu, ldAcc, dbusSelect, busy, pc, instruction};
        exp_v = {a, rd, wr, ua, la, ds, bsy, p, i};
        msk_v = {{5{ca}}, 19'h7ffff};
        n_tests++;
        if (((got_v ^ exp_v) & msk_v) != 24'h000000) begin
            n_fail++;
            $display("FAIL %s @%0t: got addr=%h rd=%b wr=%b ua=%b la=%b ds=%b busy=%b pc=%h ir=%h, want addr=%h(chk=%b) rd=%b wr=%b ua=%b la=%b ds=%b busy=%b pc=%h ir=%h",
                     nm, $time, addr, mem_rd, mem_wr, useAlu, ldAcc, dbusSelect, busy, pc, instruction,
                     a, ca, rd, wr, ua, la, ds, bsy, p, i);
        end
    endtask

    // One clock cycle of random stimulus; waits are capped so every access finishes.
    task automatic step(input bit may_wait, output bit mr);
        @(negedge tclk);
        mem_ready = may_wait ? ($urandom_range(0, 3) != 0) : 1'b1;
        z         = 1'($urandom_range(0, 1));
        #1;
        mr = mem_ready;
    endtask

    // Instruction-level reference: walks one instruction, checking every cycle.
    task automatic model_instr();
        int         waits;
        bit         mr;
        logic [2:0] op;
        logic [4:0] opd;
        waits = 0;
        do begin
            step(waits < 3, mr);
            expect_obs("fetch", 1'b1, mpc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mpc, mir);
            waits++;
        end while (!mr);
        mir = mem[mpc];
        mpc = mpc + 5'd1;
        op  = mir[7:5];
        opd = mir[4:0];
        waits = 0;
        case (op)
            3'd0, 3'd1, 3'd2: begin
                do begin
                    step(waits < 3, mr);
                    expect_obs("alu_read", 1'b1, opd, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b1, mpc, mir);
                    waits++;
                end while (!mr);
                step(1'b1, mr);
                expect_obs("alu_wb", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mpc, mir);
            end
            3'd3: begin
                step(1'b1, mr);
                expect_obs("shift_a", 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mpc, mir);
                step(1'b1, mr);
                expect_obs("shift_wb", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mpc, mir);
            end
            3'd4: begin
                do begin
                    step(waits < 3, mr);
                    expect_obs("ld", 1'b1, opd, 1'b1, 1'b0, 1'b0, mr, 1'b0, 1'b1, mpc, mir);
                    waits++;
                end while (!mr);
            end
            3'd5: begin
                step(1'b1, mr);
                expect_obs("st_a", 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mpc, mir);
                do begin
                    step(waits < 3, mr);
                    expect_obs("st_b", 1'b1, opd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mpc, mir);
                    waits++;
                end while (!mr);
            end
            3'd6: begin
                step(1'b1, mr);
                expect_obs("jmp", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mpc, mir);
                mpc = opd;
            end
            default: begin
                step(1'b1, mr);
                expect_obs("jz", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mpc, mir);
                if (z) mpc = opd;
            end
        endcase
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 8'h00;
        mem[0]  = 8'h05;
        mem[1]  = 8'hE9;
        mem[2]  = 8'hA3;
        mem[3]  = 8'hA4;
        mem[5]  = 8'h5A;
        mem[9]  = 8'hDF;
        mem[31] = 8'h80;

        //          run   mr    z     ca    addr   rd    wr    ua    la    ds    busy  pc     ir
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h01, 8'h05};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'h01, 8'h05};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 8'h05};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h02, 8'hE9};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h09, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h09, 8'hE9};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0A, 8'hDF};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h1F, 8'hDF};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'h00, 8'h80};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 8'h80};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h01, 8'h05};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'h01, 8'h05};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h01, 8'h05};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h01, 8'h05};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 8'h05};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h02, 8'hE9};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h02, 8'hE9};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h03, 8'hA3};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h03, 8'hA3};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h03, 8'hA3};
        tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h03, 8'hA3};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h03, 8'hA3};
        tbl[24] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h03, 8'hA3};

        @(negedge tclk);
        @(negedge tclk);
        reset = 1'b0;

        // Directed program: ADD, JZ taken, JMP, LD with pc wrap, run drop, JZ not taken, stalled ST.
        for (int r = 0; r < 25; r++) begin
            if (r > 0) @(negedge tclk);
            run       = tbl[r].run_i;
            mem_ready = tbl[r].mr_i;
            z         = tbl[r].z_i;
            #1;
            expect_obs($sformatf("table[%0d]", r), tbl[r].ca, tbl[r].a, tbl[r].rd, tbl[r].wr,
                       tbl[r].ua, tbl[r].la, tbl[r].ds, tbl[r].bsy, tbl[r].p, tbl[r].i);
        end

        // ST 8'hA4 stalled in EXEC_B, then reset asserted mid-cycle.
        @(negedge tclk);
        mem_ready = 1'b0;
        #1;
        expect_obs("st4_exec_a", 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h04, 8'hA4);
        @(negedge tclk);
        mem_ready = 1'b0;
        #1;
        expect_obs("st4_exec_b", 1'b1, 5'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h04, 8'hA4);
        #2;
        reset = 1'b1;
        #1;
        expect_obs("reset_in_st", 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
        @(negedge tclk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        expect_obs("after_release", 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00);

        // Random programs with random wait states and zero flag.
        for (int k = 0; k < 32; k++) mem[k] = 8'($urandom_range(0, 255));
        mpc = 5'h00;
        mir = 8'h00;
        for (int n = 0; n < 300; n++) model_instr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
